// File: rtl/fifo_arb_pkg.sv
// Shared state type, default sizing and one-hot/index helpers for the FIFO bus arbiter.
// No logic of its own; zero latency.
// No flow control.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        GAP
    } arb_state_t;

    localparam int PORT_NUM_DEF = 10;

    // Widest vector the helpers handle; callers cast down to PORT_NUM.
    localparam int MAX_PORTS = 32;

    function automatic logic [MAX_PORTS-1:0] idx2onehot(input int unsigned idx);
        return MAX_PORTS'(1) << idx;
    endfunction

    function automatic int unsigned onehot2idx(input logic [MAX_PORTS-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin winner search over req, starting at ptr and wrapping at PORT_NUM-1.
// Combinational, zero latency.
// fifo_afull suppresses winner_valid so no new grant can be issued.
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter int PORT_NUM = PORT_NUM_DEF
) (
    input  logic [PORT_NUM-1:0]         req,
    input  logic [$clog2(PORT_NUM)-1:0] ptr,
    input  logic                        fifo_afull,
    output logic                        winner_valid,
    output logic [$clog2(PORT_NUM)-1:0] winner_idx
);

    localparam int IDX_W = $clog2(PORT_NUM);

    logic [PORT_NUM-1:0] pick_oh;
    int                  pos;

    always_comb begin
        pick_oh = '0;
        pos     = 0;
        // Scan from the far end back towards ptr so the nearest requester is written last.
        for (int i = PORT_NUM - 1; i >= 0; i--) begin
            pos = (int'(ptr) + i) % PORT_NUM;
            if (req[pos]) pick_oh = PORT_NUM'(idx2onehot(pos));
        end
    end

    assign winner_idx   = IDX_W'(onehot2idx(MAX_PORTS'(pick_oh)));
    assign winner_valid = (|req) & ~fifo_afull;

endmodule

// File: rtl/fifo_bus_arbiter.sv
// Per-FIFO round-robin packet arbiter driving a one-hot bus select; optional watchdog via FIFO_ARB_TIMEOUT_EN.
// Grant 1 cycle after req; release 1 cycle after eop/abort, then a 1-cycle turnaround before the next grant.
// fifo_afull blocks new grants only; a grant already held is never revoked by it.
module fifo_bus_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int PORT_NUM       = PORT_NUM_DEF,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PORT_NUM-1:0]         req,
    input  logic [PORT_NUM-1:0]         eop,
    input  logic                        fifo_afull,
    output logic [PORT_NUM-1:0]         bus_sel,
    output logic [$clog2(PORT_NUM)-1:0] owner,
    output logic                        busy,
    output logic                        timeout_err
);

    localparam int              IDX_W    = $clog2(PORT_NUM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PORT_NUM - 1);

    arb_state_t          state, state_nxt;
    logic [PORT_NUM-1:0] bus_sel_nxt;
    logic [IDX_W-1:0]    owner_nxt;
    logic [IDX_W-1:0]    ptr, ptr_nxt;
    logic                busy_nxt;
    logic                timeout_err_nxt;
    logic                winner_valid;
    logic [IDX_W-1:0]    winner_idx;
    logic                release_pkt;
    logic                timeout_hit;

    rr_priority_pick #(
        .PORT_NUM(PORT_NUM)
    ) u_pick (
        .req         (req),
        .ptr         (ptr),
        .fifo_afull  (fifo_afull),
        .winner_valid(winner_valid),
        .winner_idx  (winner_idx)
    );

    // eop/req of non-owners never matter; only the owner's bits end a packet.
    assign release_pkt = eop[owner] | ~req[owner];

`ifdef FIFO_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wd_cnt, wd_nxt;

    assign timeout_hit = (state == BUSY) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wd_nxt = wd_cnt;
        if (state == IDLE && winner_valid) begin
            wd_nxt = '0;
        end else if (state == BUSY && !(release_pkt || timeout_hit)) begin
            wd_nxt = wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wd_cnt <= '0;
        else        wd_cnt <= wd_nxt;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt       = state;
        bus_sel_nxt     = bus_sel;
        owner_nxt       = owner;
        busy_nxt        = busy;
        ptr_nxt         = ptr;
        timeout_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (winner_valid) begin
                    state_nxt   = BUSY;
                    bus_sel_nxt = PORT_NUM'(idx2onehot(int'(winner_idx)));
                    owner_nxt   = winner_idx;
                    busy_nxt    = 1'b1;
                end
            end
            BUSY: begin
                if (release_pkt || timeout_hit) begin
                    state_nxt       = GAP;
                    bus_sel_nxt     = '0;
                    busy_nxt        = 1'b0;
                    ptr_nxt         = (owner == LAST_IDX) ? '0 : owner + 1'b1;
                    timeout_err_nxt = timeout_hit & ~release_pkt;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bus_sel     <= '0;
            owner       <= '0;
            busy        <= 1'b0;
            ptr         <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            bus_sel     <= bus_sel_nxt;
            owner       <= owner_nxt;
            busy        <= busy_nxt;
            ptr         <= ptr_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

endmodule
